// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: merges two in-order pipe results and a buffered
// long-latency LSU result stream onto two registered regfile write ports.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   p0_* / p1_*            pipe results (p0 older, p1 younger), never stalled
//   lsu_valid/ready/waddr/wdata  LSU result handshake
//   waddr0/wdata0, waddr1/wdata1 registered regfile write ports (addr 0 = idle)
//   stall_issue            registered request for issue bubbles
//   buf_count              LSU buffer occupancy
module riscv_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    input  logic [4:0]            p0_waddr,
    input  logic [31:0]           p0_wdata,
    input  logic                  p1_valid,
    input  logic [4:0]            p1_waddr,
    input  logic [31:0]           p1_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [4:0]            lsu_waddr,
    input  logic [31:0]           lsu_wdata,
    output logic [4:0]            waddr0,
    output logic [31:0]           wdata0,
    output logic [4:0]            waddr1,
    output logic [31:0]           wdata1,
    output logic                  stall_issue,
    output logic [$clog2(DEPTH):0] buf_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head1;
    logic [SW-1:0] starve;

    logic          p0_wr;
    logic          p1_wr;
    logic [1:0]    free;
    logic [1:0]    n_drain;
    logic          lsu_acc;
    logic          bypass;
    logic          enq;
    logic [4:0]    c0_addr;
    logic [31:0]   c0_data;
    logic [4:0]    c1_addr;
    logic [31:0]   c1_data;
    logic [4:0]    a0_n;
    logic [31:0]   d0_n;
    logic [4:0]    a1_n;
    logic [31:0]   d1_n;
    logic [CW-1:0] count_n;
    logic [SW-1:0] starve_n;
    logic          stall_n;

    // A bypass implies a non-full buffer, so occupancy alone decides readiness.
    assign lsu_ready = buf_count < CW'(DEPTH);

    // Port allocation, buffer drain/fill and starvation bookkeeping.
    always_comb begin
        p1_wr   = p1_valid && (p1_waddr != 5'd0);
        // Younger pipe wins a same-rd collision; the older write is dropped.
        p0_wr   = p0_valid && (p0_waddr != 5'd0) && !(p1_wr && (p0_waddr == p1_waddr));
        free    = 2'd2 - {1'b0, p0_wr} - {1'b0, p1_wr};
        lsu_acc = lsu_valid && lsu_ready;
        bypass  = lsu_acc && (lsu_waddr != 5'd0) && (buf_count < CW'(free));
        enq     = lsu_acc && (lsu_waddr != 5'd0) && !bypass;
        n_drain = (buf_count < CW'(free)) ? buf_count[1:0] : free;
        head1   = head + PW'(1);

        // Fill candidates in age order: buffer head, next entry, then LSU.
        c0_addr = 5'd0;
        c0_data = 32'd0;
        c1_addr = 5'd0;
        c1_data = 32'd0;
        if (buf_count != CW'(0)) begin
            c0_addr = buf_addr[head];
            c0_data = buf_data[head];
            if (buf_count >= CW'(2)) begin
                c1_addr = buf_addr[head1];
                c1_data = buf_data[head1];
            end else if (bypass) begin
                c1_addr = lsu_waddr;
                c1_data = lsu_wdata;
            end
        end else if (bypass) begin
            c0_addr = lsu_waddr;
            c0_data = lsu_wdata;
        end

        // p1 owns port 0, p0 owns port 1; candidates fill the lowest free port.
        a0_n = c0_addr;
        d0_n = c0_data;
        if (p1_wr) begin
            a0_n = p1_waddr;
            d0_n = p1_wdata;
        end
        a1_n = c1_addr;
        d1_n = c1_data;
        if (p0_wr) begin
            a1_n = p0_waddr;
            d1_n = p0_wdata;
        end else if (p1_wr) begin
            a1_n = c0_addr;
            d1_n = c0_data;
        end

        count_n = buf_count + CW'(enq) - CW'(n_drain);

        starve_n = starve;
        if ((buf_count == CW'(0)) || (n_drain != 2'd0)) begin
            starve_n = '0;
        end else if (starve != SW'(STARVE_LIMIT)) begin
            starve_n = starve + SW'(1);
        end

        // Set on starvation or full; hold until nearly empty and not starving.
        stall_n = (starve == SW'(STARVE_LIMIT)) || (buf_count == CW'(DEPTH)) ||
                  (stall_issue && !((buf_count <= CW'(DEPTH - 2)) && (starve == '0)));
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr0      <= 5'd0;
            wdata0      <= 32'd0;
            waddr1      <= 5'd0;
            wdata1      <= 32'd0;
            stall_issue <= 1'b0;
            buf_count   <= '0;
            head        <= '0;
            tail        <= '0;
            starve      <= '0;
        end else begin
            waddr0      <= a0_n;
            wdata0      <= d0_n;
            waddr1      <= a1_n;
            wdata1      <= d1_n;
            stall_issue <= stall_n;
            buf_count   <= count_n;
            head        <= head + PW'(n_drain);
            tail        <= tail + PW'(enq);
            starve      <= starve_n;
        end
    end

    // Buffer storage; contents are meaningless outside head..tail.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            buf_addr[tail] <= lsu_waddr;
            buf_data[tail] <= lsu_wdata;
        end
    end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
module tb_riscv_wb_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p1_valid, lsu_valid;
    logic [4:0]  p0_waddr, p1_waddr, lsu_waddr;
    logic [31:0] p0_wdata, p1_wdata, lsu_wdata;
    logic        lsu_ready;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic        stall_issue;
    logic [2:0]  buf_count;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    riscv_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_waddr(p0_waddr), .p0_wdata(p0_wdata),
        .p1_valid(p1_valid), .p1_waddr(p1_waddr), .p1_wdata(p1_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .waddr0(waddr0), .wdata0(wdata0), .waddr1(waddr1), .wdata1(wdata1),
        .stall_issue(stall_issue), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of waiting LSU results plus the port rules.
    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t        q[$];
    ent_t        e;
    logic [4:0]  m_a [2];
    logic [31:0] m_d [2];
    int          m_starve, m_sz, m_nd;
    bit          m_stall, m_acc, m_used, m_set, m_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_a[0] = 0; m_a[1] = 0; m_d[0] = 0; m_d[1] = 0;
            m_starve = 0;
            m_stall  = 0;
        end else begin
            m_sz  = q.size();
            m_acc = lsu_valid && (m_sz < DEPTH);
            m_set = (m_starve == STARVE_LIMIT) || (m_sz == DEPTH);
            m_clr = (m_sz <= DEPTH - 2) && (m_starve == 0);
            m_stall = m_set || (m_stall && !m_clr);
            m_a[0] = 0; m_a[1] = 0; m_d[0] = 0; m_d[1] = 0;
            if (p1_valid && p1_waddr != 0) begin
                m_a[0] = p1_waddr; m_d[0] = p1_wdata;
            end
            if (p0_valid && p0_waddr != 0 && !(p1_valid && p1_waddr == p0_waddr)) begin
                m_a[1] = p0_waddr; m_d[1] = p0_wdata;
            end
            m_nd = 0;
            m_used = 0;
            for (int p = 0; p < 2; p++) begin
                if (m_a[p] == 0) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        m_a[p] = e.a; m_d[p] = e.d;
                        m_nd++;
                    end else if (m_acc && lsu_waddr != 0 && !m_used) begin
                        m_a[p] = lsu_waddr; m_d[p] = lsu_wdata;
                        m_used = 1;
                    end
                end
            end
            if (m_acc && lsu_waddr != 0 && !m_used) q.push_back({lsu_waddr, lsu_wdata});
            if (m_sz > 0 && m_nd == 0) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else m_starve = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run && !rst) begin
            chk("m_waddr0", 32'(waddr0), 32'(m_a[0]));
            chk("m_waddr1", 32'(waddr1), 32'(m_a[1]));
            if (m_a[0] != 0) chk("m_wdata0", wdata0, m_d[0]);
            if (m_a[1] != 0) chk("m_wdata1", wdata1, m_d[1]);
            chk("m_buf_count", 32'(buf_count), 32'(q.size()));
            chk("m_stall", 32'(stall_issue), 32'(m_stall));
            chk("m_lsu_ready", 32'(lsu_ready), 32'(q.size() < DEPTH));
        end
    end

    task automatic apply(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic vl, input logic [4:0] al, input logic [31:0] dl);
        p0_valid = v0; p0_waddr = a0; p0_wdata = d0;
        p1_valid = v1; p1_waddr = a1; p1_wdata = d1;
        lsu_valid = vl; lsu_waddr = al; lsu_wdata = dl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic busy(input logic vl, input logic [4:0] al, input logic [31:0] dl);
        apply(1, 5'd1, 32'h1000, 1, 5'd2, 32'h2000, vl, al, dl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        p0_valid = 0; p0_waddr = 0; p0_wdata = 0;
        p1_valid = 0; p1_waddr = 0; p1_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        #1;
        chk("rst_waddr0", 32'(waddr0), 0);
        chk("rst_waddr1", 32'(waddr1), 0);
        chk("rst_buf_count", 32'(buf_count), 0);
        chk("rst_stall", 32'(stall_issue), 0);
        chk("rst_lsu_ready", 32'(lsu_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b1;

        // Two distinct pipe writes.
        apply(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 0, 0);
        chk("dual_waddr1", 32'(waddr1), 5);
        chk("dual_wdata1", wdata1, 32'h11);
        chk("dual_waddr0", 32'(waddr0), 6);
        chk("dual_wdata0", wdata0, 32'h22);

        // Same rd on both pipes: only the younger survives.
        apply(1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 0, 0, 0);
        chk("waw_waddr0", 32'(waddr0), 7);
        chk("waw_wdata0", wdata0, 32'hB);
        chk("waw_waddr1", 32'(waddr1), 0);

        // LSU bypass into the free port with only p0 writing.
        apply(1, 5'd3, 32'h33, 0, 0, 0, 1, 5'd9, 32'h55);
        chk("byp_waddr0", 32'(waddr0), 9);
        chk("byp_wdata0", wdata0, 32'h55);
        chk("byp_waddr1", 32'(waddr1), 3);
        chk("byp_count", 32'(buf_count), 0);

        // LSU write to x0 is accepted and dropped.
        apply(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h99);
        chk("x0_waddr0", 32'(waddr0), 0);
        chk("x0_waddr1", 32'(waddr1), 0);
        chk("x0_count", 32'(buf_count), 0);

        // Fill the buffer under full pipe load, then drain two per bubble.
        for (int i = 0; i < 4; i++) busy(1, 5'(10 + i), 32'h100 + 32'(i));
        chk("full_count", 32'(buf_count), 4);
        chk("full_ready", 32'(lsu_ready), 0);
        busy(1, 5'd20, 32'hDEAD);
        chk("full_stall", 32'(stall_issue), 1);
        chk("full_count_hold", 32'(buf_count), 4);
        idle();
        chk("drain1_waddr0", 32'(waddr0), 10);
        chk("drain1_wdata0", wdata0, 32'h100);
        chk("drain1_waddr1", 32'(waddr1), 11);
        chk("drain1_wdata1", wdata1, 32'h101);
        chk("drain1_count", 32'(buf_count), 2);
        idle();
        chk("drain2_waddr0", 32'(waddr0), 12);
        chk("drain2_waddr1", 32'(waddr1), 13);
        chk("drain2_count", 32'(buf_count), 0);
        chk("drain2_stall", 32'(stall_issue), 0);

        // Starvation of a single buffered entry.
        busy(1, 5'd15, 32'h77);
        chk("starve_count", 32'(buf_count), 1);
        for (int k = 1; k <= STARVE_LIMIT; k++) busy(0, 0, 0);
        chk("starve_pre", 32'(stall_issue), 0);
        busy(0, 0, 0);
        chk("starve_stall", 32'(stall_issue), 1);
        idle();
        chk("starve_drain_waddr0", 32'(waddr0), 15);
        chk("starve_drain_wdata0", wdata0, 32'h77);
        chk("starve_drain_count", 32'(buf_count), 0);
        idle();
        chk("starve_release", 32'(stall_issue), 0);

        // Single-pipe cycles with concurrent enqueue and dequeue.
        busy(1, 5'd16, 32'hA0);
        busy(1, 5'd17, 32'hA1);
        busy(1, 5'd18, 32'hA2);
        chk("mix_count3", 32'(buf_count), 3);
        apply(0, 0, 0, 1, 5'd2, 32'h202, 1, 5'd19, 32'hA3);
        chk("mix_p1_waddr0", 32'(waddr0), 2);
        chk("mix_p1_waddr1", 32'(waddr1), 16);
        chk("mix_p1_wdata1", wdata1, 32'hA0);
        chk("mix_p1_count", 32'(buf_count), 3);
        apply(1, 5'd1, 32'h301, 0, 0, 0, 0, 0, 0);
        chk("mix_p0_waddr1", 32'(waddr1), 1);
        chk("mix_p0_waddr0", 32'(waddr0), 17);
        chk("mix_p0_wdata0", wdata0, 32'hA1);
        chk("mix_p0_count", 32'(buf_count), 2);
        busy(1, 5'd21, 32'hA4);
        chk("pre_rst_count", 32'(buf_count), 3);

        // Asynchronous reset mid-cycle with a loaded buffer.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_waddr0", 32'(waddr0), 0);
        chk("arst_wdata0", wdata0, 0);
        chk("arst_waddr1", 32'(waddr1), 0);
        chk("arst_wdata1", wdata1, 0);
        chk("arst_count", 32'(buf_count), 0);
        chk("arst_stall", 32'(stall_issue), 0);
        chk("arst_ready", 32'(lsu_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        chk("post_rst_waddr0", 32'(waddr0), 0);
        chk("post_rst_waddr1", 32'(waddr1), 0);
        chk("post_rst_count", 32'(buf_count), 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: LSU result buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: cycles a buffered entry may wait before issue stall.
REQ-003 SHALL have the following ports, clock and reset first. The block uses one clock; reset is asynchronous and active-high.
- clk  in  1: rising-edge clock.
- rst  in  1: asynchronous, active-high reset.
- p0_valid  in  1: pipe 0 (older) result valid.
- p0_waddr  in  5: pipe 0 destination.
- p0_wdata  in  32: pipe 0 data.
- p1_valid  in  1: pipe 1 (younger) result valid.
- p1_waddr  in  5: pipe 1 destination.
- p1_wdata  in  32: pipe 1 data.
- lsu_valid  in  1: long-latency result offered.
- lsu_ready  out  1: result accepted this cycle.
- lsu_waddr  in  5: LSU destination.
- lsu_wdata  in  32: LSU data.
- waddr0  out  5: regfile write port 0 address (0 = no write).
- wdata0  out  32: regfile write port 0 data.
- waddr1  out  5: regfile write port 1 address (0 = no write).
- wdata1  out  32: regfile write port 1 data.
- stall_issue  out  1: request issue stage to inject bubbles.
- buf_count  out  clog2(DEPTH)+1: current buffer occupancy.

Function
REQ-004 SHALL register waddr0/wdata0/waddr1/wdata1; latency from accepted input to port output is exactly 1 cycle.
REQ-005 SHALL treat any request with waddr==0 as no write, consuming no port; an LSU request to x0 is still accepted (lsu_ready handshake) and discarded.
REQ-006 SHALL give pipes absolute priority, with no backpressure: p0 write drives port 1, p1 write drives port 0.
REQ-007 SHALL, when p0 and p1 both write the same nonzero rd, suppress the p0 write, so only p1 (younger) is written.
REQ-008 SHALL compute free ports = 2 - pipe writes this cycle; free ports are filled first from the buffer head (oldest entry to lowest-index free port), then by the bypassed LSU request.
REQ-009 SHALL bypass lsu directly to a free port, without enqueue, only when the buffer holds fewer entries than the free ports.
REQ-010 SHALL enqueue an accepted, non-bypassed LSU request at the tail; lsu_ready = (buf_count < DEPTH) OR (bypass possible this cycle), combinational.
REQ-011 SHALL drain up to 2 buffer entries per cycle; simultaneous enqueue and dequeue at full SHALL keep count correct with no loss or duplication.
REQ-012 SHALL manage buffer pointers as wrapping log2(DEPTH)-bit indices; buf_count ranges 0..DEPTH.
REQ-013 SHALL hold a starve counter that increments each cycle with buf_count>0 and zero entries drained, clears on any drain or when empty, and saturates at STARVE_LIMIT.
REQ-014 SHALL assert stall_issue (registered) while starve counter == STARVE_LIMIT or buf_count == DEPTH, deasserting the cycle after buf_count drops to ≤ DEPTH-2 and the counter clears.
REQ-015 SHALL not perform WAW ordering between LSU and pipe results; the scoreboard guarantees none exist.
REQ-016 SHALL keep port 0 and port 1 addresses distinct whenever both are nonzero.

Reset
REQ-017 SHALL, on rst high (asynchronous), clear waddr0/1, wdata0/1, stall_issue, buf_count, pointers and starve counter to 0; lsu_ready is then 1.
REQ-018 SHALL accept no request in a cycle where rst is high; a reset mid-drain discards all buffered entries.

Verification
REQ-019 Scenario: p0 {x5,0x11}, p1 {x6,0x22}, no LSU. Required response: next cycle waddr1=5, wdata1=0x11, waddr0=6, wdata0=0x22.
REQ-020 Scenario: p0 and p1 both write x7 (0xA, 0xB). Required response: next cycle waddr0=7, wdata0=0xB, waddr1=0.
REQ-021 Scenario: LSU {x9,0x55} with p0 only valid, buffer empty. Required response: bypass; next cycle waddr0=9, wdata0=0x55, buf_count=0.
REQ-022 Scenario: both pipes writing every cycle while 4 LSU results are sent. Required response: buf_count reaches 4, lsu_ready=0, stall_issue=1; on pipe bubble 2 entries drain per cycle in FIFO order.
REQ-023 Scenario: 1 buffered entry, pipes busy for 8 cycles. Required response: stall_issue rises after STARVE_LIMIT; falls after the drain.
REQ-024 Scenario: rst asserted with buf_count=3. Required response: all outputs 0 and buf_count=0 immediately, without waiting for a clock edge.
